// File: rtl/mips16_pkg.sv
// rtl/mips16_pkg.sv - shared opcodes, fetch states and constants for the 16-bit MIPS pipeline
package mips16_pkg;

    localparam logic [5:0] OPC_NOP = 6'b000000;
    localparam logic [5:0] OPC_JMP = 6'b000010;
    localparam logic [5:0] OPC_LW  = 6'b100011;
    localparam logic [5:0] OPC_HLT = 6'b010001;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        FLUSH,
        HALTED
    } fetch_state_e;

endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - fetch program counter with hold, load and wrapping increment
module program_counter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;

    // Load beats hold so a redirect is never lost behind a stall.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_addr_i;
        end else if (!hold_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - IF stage: PC control, IF/ID hold register and fetch FSM
module instruction_fetch_unit
    import mips16_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               stall_pm,
    input  logic               jump_valid,
    input  logic [ADDR_W-1:0]  jump_target,
    output logic [ADDR_W-1:0]  pm_addr,
    input  logic [INSTR_W-1:0] pm_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic [5:0]         op_out,
    output logic               halted
);

    localparam logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(INSTR_NOP);

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] hold_q, hold_d;
    logic               pc_hold, pc_load;

    program_counter #(.ADDR_W(ADDR_W)) u_pc (
        .clk         (clk),
        .reset       (reset),
        .hold_i      (pc_hold),
        .load_i      (pc_load),
        .load_addr_i (jump_target),
        .pc_o        (pm_addr)
    );

    // Only RUN shows a real word; stall_pm replays the word captured last cycle.
    always_comb begin
        instr_out   = NOP_WORD;
        instr_valid = 1'b0;
        if (state_q == RUN) begin
            instr_out   = stall_pm ? hold_q : pm_rdata;
            instr_valid = 1'b1;
        end
    end

    assign op_out = instr_out[INSTR_W-1 -: 6];
    assign halted = (state_q == HALTED);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pc_hold = 1'b1;
        pc_load = 1'b0;
        case (state_q)
            FILL: begin
                pc_hold = 1'b0;
                state_d = RUN;
            end
            RUN: begin
                hold_d = instr_out;
                if (jump_valid) begin
                    pc_load = 1'b1;
                    state_d = FLUSH;
                end else if (op_out == OPC_HLT) begin
                    state_d = HALTED;
                end else if (!stall) begin
                    pc_hold = 1'b0;
                end
            end
            FLUSH: begin
                pc_hold = 1'b0;
                state_d = RUN;
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
            hold_q  <= NOP_WORD;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

endmodule
